// File: rtl/cic_decimator.sv
// Dual-channel (sin/cos) Hogenauer CIC decimator: STAGES integrators, decimate by 2^DECIM_LOG2, STAGES pipelined combs.
// Optional build macro CIC_ROUND_EN: round half up with positive saturation instead of plain truncation.
module cic_decimator #(
    parameter int WIDTH      = 12,
    parameter int OUT_WIDTH  = 12,
    parameter int STAGES     = 5,
    parameter int DECIM_LOG2 = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic signed [WIDTH-1:0]     in_sin,
    input  logic signed [WIDTH-1:0]     in_cos,
    output logic                        out_valid,
    output logic signed [OUT_WIDTH-1:0] out_sin,
    output logic signed [OUT_WIDTH-1:0] out_cos
);
    localparam int ACC = WIDTH + STAGES * DECIM_LOG2;
    localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;

    typedef logic signed [ACC-1:0] acc_t;

    acc_t                  x_sin, x_cos;
    logic                  v;
    acc_t                  int_sin [STAGES];
    acc_t                  int_cos [STAGES];
    logic [DECIM_LOG2-1:0] cnt;
    logic                  strobe;
    acc_t                  c_sin [STAGES+1];
    acc_t                  c_cos [STAGES+1];
    acc_t                  d_sin [STAGES];
    acc_t                  d_cos [STAGES];
    logic [STAGES:0]       cv;

`ifdef CIC_ROUND_EN
    localparam logic [ACC:0] RND = (ACC+1)'(1) << (ACC - OUT_WIDTH - 1);

    function automatic logic signed [OUT_WIDTH-1:0] round_sat(input acc_t c);
        logic [ACC:0] s;
        s = {c[ACC-1], c} + RND;
        // only a positive value can overflow when adding the half-LSB
        if (!s[ACC] && s[ACC-1])
            return {1'b0, {(OUT_WIDTH-1){1'b1}}};
        return s[ACC-1 -: OUT_WIDTH];
    endfunction
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_sin <= '0;
            x_cos <= '0;
            v     <= 1'b0;
        end else begin
            x_sin <= {{(ACC-WIDTH){in_sin[WIDTH-1]}}, in_sin};
            x_cos <= {{(ACC-WIDTH){in_cos[WIDTH-1]}}, in_cos};
            v     <= in_valid;
        end
    end

    // Integrators wrap modulo 2^ACC; each stage consumes the previous stage's pre-update value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                int_sin[k] <= '0;
                int_cos[k] <= '0;
            end
            cnt <= '0;
        end else if (v) begin
            int_sin[0] <= int_sin[0] + x_sin;
            int_cos[0] <= int_cos[0] + x_cos;
            for (int k = 1; k < STAGES; k++) begin
                int_sin[k] <= int_sin[k] + int_sin[k-1];
                int_cos[k] <= int_cos[k] + int_cos[k-1];
            end
            cnt <= cnt + 1'b1;
        end
    end

    assign strobe = v && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= STAGES; k++) begin
                c_sin[k] <= '0;
                c_cos[k] <= '0;
            end
            for (int k = 0; k < STAGES; k++) begin
                d_sin[k] <= '0;
                d_cos[k] <= '0;
            end
            cv <= '0;
        end else begin
            cv <= {cv[STAGES-1:0], strobe};
            if (strobe) begin
                c_sin[0] <= int_sin[STAGES-1];
                c_cos[0] <= int_cos[STAGES-1];
            end
            for (int k = 1; k <= STAGES; k++) begin
                if (cv[k-1]) begin
                    c_sin[k]   <= c_sin[k-1] - d_sin[k-1];
                    c_cos[k]   <= c_cos[k-1] - d_cos[k-1];
                    d_sin[k-1] <= c_sin[k-1];
                    d_cos[k-1] <= c_cos[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sin   <= '0;
            out_cos   <= '0;
        end else begin
            out_valid <= cv[STAGES];
            if (cv[STAGES]) begin
`ifdef CIC_ROUND_EN
                out_sin <= round_sat(c_sin[STAGES]);
                out_cos <= round_sat(c_cos[STAGES]);
`else
                out_sin <= c_sin[STAGES][ACC-1 -: OUT_WIDTH];
                out_cos <= c_cos[STAGES][ACC-1 -: OUT_WIDTH];
`endif
            end
        end
    end
endmodule

// File: tb/tb_cic_decimator.sv
// Bench for cic_decimator: random and directed streams checked against a convolution model of the CIC response.
module tb_cic_decimator;
    localparam int WIDTH = 12;
    localparam int OW    = 12;
    localparam int OW2   = 10;
    localparam int N     = 5;
    localparam int DL    = 8;
    localparam int R     = 1 << DL;
    localparam int ACC   = WIDTH + N * DL;
    localparam int HLEN  = N * (R - 1) + 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic signed [WIDTH-1:0] in_sin, in_cos;
    logic                    out_valid, out_valid10;
    logic signed [OW-1:0]    out_sin, out_cos;
    logic signed [OW2-1:0]   out_sin10, out_cos10;

    cic_decimator #(.WIDTH(WIDTH), .OUT_WIDTH(OW), .STAGES(N), .DECIM_LOG2(DL)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sin(in_sin), .in_cos(in_cos),
        .out_valid(out_valid), .out_sin(out_sin), .out_cos(out_cos));

    cic_decimator #(.WIDTH(WIDTH), .OUT_WIDTH(OW2), .STAGES(N), .DECIM_LOG2(DL)) dut10 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sin(in_sin), .in_cos(in_cos),
        .out_valid(out_valid10), .out_sin(out_sin10), .out_cos(out_cos10));

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int es;
        int ec;
        int es10;
        int ec10;
    } exp_t;

    int     vectors = 0;
    int     errors  = 0;
    int     cyc     = 0;
    int     nsamp   = 0;
    longint h [HLEN];
    longint t [HLEN];
    int     hs[$];
    int     hc[$];
    exp_t   q[$];
    int     last_s = 0, last_c = 0, last_s10 = 0, last_c10 = 0;

    // y_k = sum_d h[d] * x[kR - N - d] (1-based sample index, zero history before reset release)
    function automatic longint filt(input bit cos_ch, input int k);
        longint acc = 0;
        for (int d = 0; d < HLEN; d++) begin
            int idx = k * R - N - d - 1;
            if (idx < 0) break;
            acc += h[d] * longint'(cos_ch ? hc[idx] : hs[idx]);
        end
        return acc;
    endfunction

    function automatic int scale(input longint y, input int ow);
        int     sh = ACC - ow;
        longint r;
`ifdef CIC_ROUND_EN
        r = (y + (longint'(1) << (sh - 1))) >>> sh;
        if (r > longint'((1 << (ow - 1)) - 1)) r = longint'((1 << (ow - 1)) - 1);
`else
        r = y >>> sh;
`endif
        return int'(r);
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic v, input int s, input int c);
        logic   rst_e, v_e, ev;
        int     s_e, c_e;
        longint ys, yc;
        exp_t   e;
        rst_e = rst;
        v_e   = in_valid;
        s_e   = int'(in_sin);
        c_e   = int'(in_cos);
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_e && v_e) begin
            hs.push_back(s_e);
            hc.push_back(c_e);
            nsamp++;
            if (nsamp % R == 0) begin
                ys     = filt(1'b0, nsamp / R);
                yc     = filt(1'b1, nsamp / R);
                e.due  = cyc + N + 2;
                e.es   = scale(ys, OW);
                e.ec   = scale(yc, OW);
                e.es10 = scale(ys, OW2);
                e.ec10 = scale(yc, OW2);
                q.push_back(e);
            end
        end
        ev = (q.size() > 0) && (q[0].due == cyc);
        if (ev) begin
            last_s   = q[0].es;
            last_c   = q[0].ec;
            last_s10 = q[0].es10;
            last_c10 = q[0].ec10;
            void'(q.pop_front());
        end
        vectors++;
        assert (out_valid === ev) else begin
            errors++;
            $error("FAIL out_valid cyc=%0d: observed %b expected %b", cyc, out_valid, ev);
        end
        assert (out_valid10 === ev) else begin
            errors++;
            $error("FAIL out_valid10 cyc=%0d: observed %b expected %b", cyc, out_valid10, ev);
        end
        assert (out_sin === OW'(last_s) && out_cos === OW'(last_c)) else begin
            errors++;
            $error("FAIL out12 cyc=%0d: observed %0d/%0d expected %0d/%0d", cyc, out_sin, out_cos, last_s, last_c);
        end
        assert (out_sin10 === OW2'(last_s10) && out_cos10 === OW2'(last_c10)) else begin
            errors++;
            $error("FAIL out10 cyc=%0d: observed %0d/%0d expected %0d/%0d", cyc, out_sin10, out_cos10, last_s10, last_c10);
        end
        rst      = r;
        in_valid = v;
        in_sin   = WIDTH'(s);
        in_cos   = WIDTH'(c);
        if (r) begin
            hs.delete();
            hc.delete();
            q.delete();
            nsamp    = 0;
            last_s   = 0;
            last_c   = 0;
            last_s10 = 0;
            last_c10 = 0;
        end
    endtask

    function automatic int rnd_sample();
        return int'($urandom_range(4095)) - 2048;
    endfunction

    initial begin
        int len;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sin   = '0;
        in_cos   = '0;

        for (int i = 0; i < HLEN; i++) h[i] = 0;
        h[0] = 1;
        len  = 1;
        repeat (N) begin
            for (int i = 0; i < HLEN; i++) t[i] = 0;
            for (int i = 0; i < len; i++)
                for (int j = 0; j < R; j++) t[i + j] += h[i];
            len += R - 1;
            h = t;
        end

        // reset held with random inputs
        repeat (10) cycle(1'b1, 1'($urandom_range(1)), rnd_sample(), rnd_sample());

        // DC
        repeat (10 * R) cycle(1'b0, 1'b1, 5, -7);
        chk("dc_sin", int'(out_sin), 5);
        chk("dc_cos", int'(out_cos), -7);

        // full scale with integrator wrap
        repeat (20 * R) cycle(1'b0, 1'b1, -2048, 2047);
        chk("fs_sin", int'(out_sin), -2048);
        chk("fs_cos", int'(out_cos), 2047);
        chk("fs_sin10", int'(out_sin10), -512);
        chk("fs_cos10_sat", int'(out_cos10), 511);

        // reset mid block, then gapped input
        repeat (100) cycle(1'b0, 1'b1, 100, -100);
        cycle(1'b1, 1'b1, 100, -100);
        for (int i = 0; i < 12 * R * 2; i++) cycle(1'b0, 1'(i % 2 == 0), 100, -100);
        chk("gap_sin", int'(out_sin), 100);
        chk("gap_cos", int'(out_cos), -100);

        // rounding versus truncation at 10-bit output
        repeat (10 * R) cycle(1'b0, 1'b1, 3, -3);
        chk("x3_sin", int'(out_sin), 3);
`ifdef CIC_ROUND_EN
        chk("x3_sin10", int'(out_sin10), 1);
`else
        chk("x3_sin10", int'(out_sin10), 0);
`endif
        chk("x3_cos10", int'(out_cos10), -1);

        // random data with random gaps, and a reset in the middle
        repeat (8000) cycle(1'b0, 1'($urandom_range(3) != 0), rnd_sample(), rnd_sample());
        cycle(1'b1, 1'b1, rnd_sample(), rnd_sample());
        repeat (2000) cycle(1'b0, 1'($urandom_range(3) != 0), rnd_sample(), rnd_sample());
        repeat (20) cycle(1'b0, 1'b0, 0, 0);
        chk("pending_pulses", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
